// File: rtl/pipe_stage_pkg.sv
// pipe_stage_pkg: definitions shared by the pipeline-stage buffer and its
// performance-counter sub-module.
//   PERF_W     : width of the optional stall/bubble counters.
//   perf_cnt_t : counter type.
//   ptr_inc    : circular pointer increment that wraps from depth-1 to 0,
//                so any depth works, not only powers of two.
package pipe_stage_pkg;

    localparam int unsigned PERF_W = 32;

    typedef logic [PERF_W-1:0] perf_cnt_t;

    function automatic int unsigned ptr_inc(input int unsigned ptr,
                                            input int unsigned depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/pipe_stage_perf.sv
// pipe_stage_perf: two saturating event counters for a pipeline-stage buffer.
// Both counters clear only on RST and stop at all-ones.
// Ports:
//   CLK, RST   : clock, synchronous active-high reset
//   stall_evt  : upstream offered data that was refused this cycle
//   bubble_evt : downstream was ready but nothing was valid this cycle
//   stall_cnt  : count of stall_evt cycles
//   bubble_cnt : count of bubble_evt cycles
module pipe_stage_perf
    import pipe_stage_pkg::*;
(
    input  logic      CLK,
    input  logic      RST,
    input  logic      stall_evt,
    input  logic      bubble_evt,
    output perf_cnt_t stall_cnt,
    output perf_cnt_t bubble_cnt
);

    perf_cnt_t stall_q, stall_d;
    perf_cnt_t bubble_q, bubble_d;

    always_comb begin
        stall_d  = stall_q;
        bubble_d = bubble_q;
        if (stall_evt && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
        if (bubble_evt && (bubble_q != '1)) begin
            bubble_d = bubble_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: generic pipeline-stage buffer carrying an opaque DATA_W-bit
// payload with a valid/ready handshake, synchronous flush and DEPTH entries.
// DEPTH=1 acts as the classic enable/flush register (in_ready combinational
// from out_ready); DEPTH>=2 is a skid FIFO whose in_ready depends only on
// registered occupancy.
// Optional feature macro: PIPE_STAGE_BUF_PERF_EN adds stall_cnt/bubble_cnt.
// Ports:
//   CLK, RST   : clock, synchronous active-high reset (priority over flush)
//   flush      : drop all held entries at the next edge (beats push/pop)
//   in_valid   : upstream offers in_data
//   in_ready   : buffer accepts this cycle
//   in_data    : payload from upstream
//   out_valid  : out_data holds a valid entry
//   out_ready  : downstream consumes the head entry
//   out_data   : head entry, driven from storage (no in_data->out_data path)
//   occupancy  : number of held entries
//   stall_cnt, bubble_cnt : saturating perf counters (macro only)
module pipe_stage_buf
    import pipe_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef PIPE_STAGE_BUF_PERF_EN
    ,
    output logic [PERF_W-1:0]          stall_cnt,
    output logic [PERF_W-1:0]          bubble_cnt
`endif
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic              push;
    logic              pop;

    assign out_valid = (occ_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign occupancy = occ_q;

    // Single entry: a pop frees the slot in the same cycle, so ready follows
    // out_ready for full throughput. Deeper buffers keep ready registered to
    // break the combinational ready chain between stages.
    generate
        if (DEPTH == 1) begin : g_ready_comb
            assign in_ready = !out_valid || out_ready;
        end else begin : g_ready_reg
            assign in_ready = (32'(occ_q) < DEPTH);
        end
    endgenerate

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = PTR_W'(ptr_inc(32'(wr_ptr_q), DEPTH));
            end
            if (pop) begin
                rd_ptr_d = PTR_W'(ptr_inc(32'(rd_ptr_q), DEPTH));
            end
            if (push && !pop) begin
                occ_d = occ_q + 1'b1;
            end else if (pop && !push) begin
                occ_d = occ_q - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
            // A push offered during flush is dropped without touching storage.
            if (push && !flush) begin
                mem_q[wr_ptr_q] <= in_data;
            end
        end
    end

`ifdef PIPE_STAGE_BUF_PERF_EN
    pipe_stage_perf u_perf (
        .CLK        (CLK),
        .RST        (RST),
        .stall_evt  (in_valid && !in_ready),
        .bubble_evt (!out_valid && out_ready),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );
`endif

endmodule
